// File: rtl/adc_calc_val_bank.sv
// Per-channel gain/offset operand bank for the ADC float pipeline.
// PS writes land in a shadow bank; a frame start commits (if armed) and streams one beat per operand.

module adc_cvb_lane #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DEF_GAIN   = 32'h32000000,
  parameter logic [DATA_WIDTH-1:0] DEF_OFFSET = 32'hbf800000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_gain,
  input  logic                  i_wr_offset,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_commit,
  input  logic                  i_launch,
  input  logic                  i_gain_tready,
  input  logic                  i_offset_tready,
  output logic [DATA_WIDTH-1:0] o_gain,
  output logic [DATA_WIDTH-1:0] o_offset,
  output logic                  o_gain_tvalid,
  output logic                  o_offset_tvalid
);
  logic [DATA_WIDTH-1:0] shd_gain, shd_offset, act_gain, act_offset;
  logic                  gain_vld, offset_vld;

  // Commit samples the shadow before any same-cycle write lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shd_gain   <= DEF_GAIN;
      shd_offset <= DEF_OFFSET;
      act_gain   <= DEF_GAIN;
      act_offset <= DEF_OFFSET;
    end else begin
      if (i_wr_gain)   shd_gain   <= i_wr_data;
      if (i_wr_offset) shd_offset <= i_wr_data;
      if (i_commit) begin
        act_gain   <= shd_gain;
        act_offset <= shd_offset;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gain_vld   <= 1'b0;
      offset_vld <= 1'b0;
    end else begin
      if (i_launch)           gain_vld   <= 1'b1;
      else if (i_gain_tready) gain_vld   <= 1'b0;
      if (i_launch)             offset_vld <= 1'b1;
      else if (i_offset_tready) offset_vld <= 1'b0;
    end
  end

  assign o_gain          = act_gain;
  assign o_offset        = act_offset;
  assign o_gain_tvalid   = gain_vld;
  assign o_offset_tvalid = offset_vld;
endmodule

module adc_calc_val_bank #(
  parameter int                    CH_NUM     = 2,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DEF_GAIN   = 32'h32000000,
  parameter logic [DATA_WIDTH-1:0] DEF_OFFSET = 32'hbf800000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic                         i_wr_sel,
  input  logic [2:0]                   i_wr_ch,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic                         i_update,
  input  logic                         i_frame_start,
  output logic [CH_NUM*DATA_WIDTH-1:0] o_gain_axis_tdata,
  output logic [CH_NUM-1:0]            o_gain_axis_tvalid,
  input  logic [CH_NUM-1:0]            i_gain_axis_tready,
  output logic [CH_NUM*DATA_WIDTH-1:0] o_offset_axis_tdata,
  output logic [CH_NUM-1:0]            o_offset_axis_tvalid,
  input  logic [CH_NUM-1:0]            i_offset_axis_tready,
  output logic                         o_upd_pending,
  output logic                         o_busy,
  output logic [15:0]                  o_overrun_cnt
);
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                               state, state_nxt;
  logic                                 pending, commit, launch, overrun, remaining;
  logic [15:0]                          ovr_cnt;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0]    gain_data, offset_data;
  logic [CH_NUM-1:0]                    gain_vld, offset_vld;

  // i_rst_n is expected to be deasserted synchronously to i_clk by the reset tree.
  genvar g;
  generate
    for (g = 0; g < CH_NUM; g++) begin : gen_lane
      adc_cvb_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEF_GAIN   (DEF_GAIN),
        .DEF_OFFSET (DEF_OFFSET)
      ) u_lane (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_wr_gain       (i_wr_en && !i_wr_sel && (i_wr_ch == 3'(g))),
        .i_wr_offset     (i_wr_en &&  i_wr_sel && (i_wr_ch == 3'(g))),
        .i_wr_data       (i_wr_data),
        .i_commit        (commit),
        .i_launch        (launch),
        .i_gain_tready   (i_gain_axis_tready[g]),
        .i_offset_tready (i_offset_axis_tready[g]),
        .o_gain          (gain_data[g]),
        .o_offset        (offset_data[g]),
        .o_gain_tvalid   (gain_vld[g]),
        .o_offset_tvalid (offset_vld[g])
      );
    end
  endgenerate

  // Beats still outstanding after this cycle's handshakes.
  assign remaining = |(gain_vld & ~i_gain_axis_tready) | |(offset_vld & ~i_offset_axis_tready);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    commit    = 1'b0;
    overrun   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_frame_start) begin
          launch    = 1'b1;
          commit    = pending | i_update;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        overrun = i_frame_start;
        if (!remaining) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      ovr_cnt <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (commit)        pending <= 1'b0;
      else if (i_update) pending <= 1'b1;
      if (overrun && ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'h0001;
    end
  end

  assign o_gain_axis_tdata    = gain_data;
  assign o_offset_axis_tdata  = offset_data;
  assign o_gain_axis_tvalid   = gain_vld;
  assign o_offset_axis_tvalid = offset_vld;
  assign o_busy               = |{gain_vld, offset_vld};
  assign o_upd_pending        = pending;
  assign o_overrun_cnt        = ovr_cnt;
endmodule

// File: doc/adc_calc_val_bank.md
Name: adc_calc_val_bank

Overview:
- Parametrised, runtime-programmable source of gain and offset operands for the MPS ADC float pipeline: RESULT = ((raw * gain) + offset) * factor.
- Holds one gain and one offset per channel in double-buffered registers. PS writes go to a shadow bank, which is committed atomically at a frame boundary.
- On each ADC frame start, presents one gain beat and one offset beat per channel on AXI-Stream, with full tvalid/tready handshake, to the Floating Point IP inputs.

Parameters:
- CH_NUM, 2, number of channels (1..8); channel 0 = current, channel 1 = voltage.
- DATA_WIDTH, 32, operand width (IEEE-754 single).
- DEF_GAIN, 32'h32000000, reset gain (7.45058e-9) for every channel.
- DEF_OFFSET, 32'hbf800000, reset offset (-1.0) for every channel.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_en  in  1  shadow write strobe (1 cycle)
- i_wr_sel  in  1  0 = gain, 1 = offset
- i_wr_ch  in  3  target channel index
- i_wr_data  in  DATA_WIDTH  write value
- i_update  in  1  arm commit of shadow to active at next frame start
- i_frame_start  in  1  ADC frame-start pulse
- o_gain_axis_tdata  out  CH_NUM*DATA_WIDTH  per-channel gain, ch n at [n*DW +: DW]
- o_gain_axis_tvalid  out  CH_NUM  per-channel valid
- i_gain_axis_tready  in  CH_NUM  per-channel ready
- o_offset_axis_tdata  out  CH_NUM*DATA_WIDTH  per-channel offset
- o_offset_axis_tvalid  out  CH_NUM
- i_offset_axis_tready  in  CH_NUM
- o_upd_pending  out  1  commit armed, not yet applied
- o_busy  out  1  any tvalid high
- o_overrun_cnt  out  16  frame starts dropped while busy (saturating)

Behaviour:
- Reset (async assert, sync release): shadow and active = defaults; all tvalid = 0; o_upd_pending = 0; o_busy = 0; o_overrun_cnt = 0. tdata outputs show active values.
- Shadow write: on i_wr_en, write shadow[i_wr_ch][i_wr_sel] <= i_wr_data.
  - i_wr_ch >= CH_NUM: write ignored, no error.
  - Writes never change the active bank or tdata directly.
- i_update: sets o_upd_pending next cycle. Repeated i_update while pending has no further effect.
- Frame FSM (single controller, states IDLE and SEND):
  - IDLE + i_frame_start: if pending (or i_update in the same cycle), active <= shadow and pending cleared.
  - Next cycle, all 2*CH_NUM tvalid = 1, tdata = new active values; state = SEND.
  - Latency: frame start to tvalid = 1 cycle.
- SEND:
  - Each tvalid clears independently on its own tvalid & tready.
  - tdata is stable while its tvalid is high (AXIS rule). Active is never updated in SEND.
  - Leave SEND when all tvalid are 0. If the last handshake cycle also carries i_frame_start, it is treated as an overrun; no back-to-back restart.
- o_busy = OR of all tvalid (registered with them).
- i_frame_start in SEND: o_overrun_cnt += 1, saturating at 16'hFFFF; no state change.
- Same-cycle i_wr_en and commit: commit copies the pre-write shadow. The write lands in shadow and is applied only after a later i_update plus frame start.
- tready held high before tvalid is legal; the handshake still occurs only when tvalid = 1.
- Reset mid-SEND: tvalid drops immediately, all registers return to defaults, and no beat is completed.

Test Plan:
- Reset release, frame_start, all tready = 1 -> 1 cycle later all tvalid = 1, gain = 32'h32000000, offset = 32'hbf800000; after 1 cycle all tvalid = 0, o_busy = 0.
- Write ch1 gain = 32'h3F800000 with no update, frame_start -> ch1 gain still 32'h32000000. Then i_update and frame_start -> ch1 gain = 32'h3F800000, o_upd_pending 1 -> 0.
- ch0 offset tready held 0 for 5 cycles with others ready -> only ch0 offset tvalid remains high, tdata stable, o_busy = 1. Release -> SEND exits.
- frame_start twice while busy -> o_overrun_cnt = 2, outputs unchanged. Preload 16'hFFFE plus 3 overruns -> count stays 16'hFFFF.
- i_wr_en (ch0 gain = 32'h40000000) in the same cycle as frame_start with pending -> committed value is the prior shadow. 32'h40000000 appears only after the next update and frame.
- Write with i_wr_ch = 5 when CH_NUM = 2 -> no register changes. i_rst_n pulled low mid-SEND -> tvalid = 0 asynchronously, defaults restored.
